// File: rtl/rom_loader.sv
// HPS ioctl byte download packed into 16-bit toggle-handshake word writes for the DDRAM controller.
// Defining ROM_LOADER_BYTESWAP_EN adds a byteswap input that selects little-endian word packing.

// Generic synchronous FIFO with occupancy count and synchronous clear.
// Latency: a pushed entry is visible at head_dat on the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module rom_loader_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Packs ioctl download bytes into words and issues them on the wraddr/din/we_req toggle handshake.
// Latency: a packed word is requested one cycle after it reaches the FIFO head with no request pending.
// Backpressure: ioctl_wait at FIFO_DEPTH-1 entries; bytes arriving at full FIFO are dropped and flag overrun.
module rom_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [27:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
`ifdef ROM_LOADER_BYTESWAP_EN
    input  logic        byteswap,
`endif
    output logic        ioctl_wait,
    output logic [27:0] wraddr,
    output logic [15:0] din,
    output logic        we_req,
    input  logic        we_ack,
    output logic        load_done,
    output logic        overrun
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_WAIT = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_t;

    typedef struct packed {
        logic [26:0] addr;
        logic [15:0] word;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic          dl_q;
    logic          half;
    logic [7:0]    hi_byte;
    logic [26:0]   hi_addr;
    logic          got_byte;
    logic [27:0]   max_addr;
    logic          busy;
    logic          swap_q;
    entry_t        push_dat;
    entry_t        head_dat;
    logic          push_vld;
    logic          pop_vld;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          start;
    logic          req_pend;
    logic          engine_on;
    logic          issue;
    logic          byte_vld;
    logic          byte_ok;
    logic          byte_drop;
    logic          flush_push;
    logic          done_go;

    function automatic logic [15:0] pack_word(input logic [7:0] even_b,
                                              input logic [7:0] odd_b,
                                              input logic       swap);
        return swap ? {odd_b, even_b} : {even_b, odd_b};
    endfunction

`ifdef ROM_LOADER_BYTESWAP_EN
    always_ff @(posedge clk_sys) begin
        if (reset)      swap_q <= 1'b0;
        else if (start) swap_q <= byteswap;
    end
`else
    assign swap_q = 1'b0;
`endif

    assign start      = (state == ST_IDLE) && ioctl_download && !dl_q;
    assign req_pend   = we_req ^ we_ack;
    assign engine_on  = (state == ST_LOAD) || (state == ST_FLUSH);
    assign pop_vld    = engine_on && busy && !req_pend;
    assign issue      = engine_on && !busy && !fifo_empty && !req_pend;
    assign byte_vld   = (state == ST_LOAD) && ioctl_wr;
    assign byte_drop  = byte_vld && fifo_full;
    assign byte_ok    = byte_vld && !fifo_full;
    assign flush_push = (state == ST_FLUSH) && half && (!fifo_full || pop_vld);
    assign done_go    = (state == ST_FLUSH) && (state_nxt == ST_DONE);
    assign ioctl_wait = (fifo_count >= CNT_WAIT);

    // Odd byte completes its word; an even byte over a pending half word pushes the padded old one.
    always_comb begin
        push_vld      = 1'b0;
        push_dat.addr = hi_addr;
        push_dat.word = pack_word(hi_byte, PAD_BYTE, swap_q);
        if (byte_ok && ioctl_addr[0]) begin
            push_vld      = 1'b1;
            push_dat.addr = ioctl_addr[27:1];
            push_dat.word = pack_word(half ? hi_byte : PAD_BYTE, ioctl_dout, swap_q);
        end else if (byte_ok && half) begin
            push_vld = 1'b1;
        end else if (flush_push) begin
            push_vld = 1'b1;
        end
    end

    rom_loader_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .clr      (start),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_done = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_nxt = ST_FLUSH;
            ST_FLUSH: if (!half && fifo_empty && !req_pend) state_nxt = ST_DONE;
            ST_DONE: begin
                load_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // dl_q reloads from ioctl_download so a download already in progress at reset is not resumed.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q     <= ioctl_download;
            we_req   <= we_ack;
            wraddr   <= '0;
            din      <= '0;
            overrun  <= 1'b0;
            half     <= 1'b0;
            hi_byte  <= '0;
            hi_addr  <= '0;
            busy     <= 1'b0;
            got_byte <= 1'b0;
            max_addr <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (start) begin
                wraddr   <= '0;
                overrun  <= 1'b0;
                half     <= 1'b0;
                busy     <= 1'b0;
                got_byte <= 1'b0;
                max_addr <= '0;
            end else begin
                if (issue) begin
                    wraddr <= {head_dat.addr, 1'b0};
                    din    <= head_dat.word;
                    we_req <= ~we_req;
                    busy   <= 1'b1;
                end
                if (pop_vld)   busy    <= 1'b0;
                if (byte_drop) overrun <= 1'b1;
                if (byte_ok) begin
                    got_byte <= 1'b1;
                    if (!got_byte || (ioctl_addr > max_addr)) max_addr <= ioctl_addr;
                    if (ioctl_addr[0]) begin
                        half <= 1'b0;
                    end else begin
                        half    <= 1'b1;
                        hi_byte <= ioctl_dout;
                        hi_addr <= ioctl_addr[27:1];
                    end
                end
                if (flush_push) half <= 1'b0;
                if (done_go) wraddr <= got_byte ? {max_addr[27:1] + 27'd1, 1'b0} : 28'd0;
            end
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: randomized host downloads against a word-list model and a toggle-ack controller.
// Latency: checks are made on the falling clock edge, away from the DUT's active edge.
// Backpressure: the controller model can freeze we_ack to fill the FIFO and exercise ioctl_wait.
module tb_rom_loader;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  PAD   = 8'h00;

    logic        clk_sys        = 1'b0;
    logic        reset          = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [27:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
`ifdef ROM_LOADER_BYTESWAP_EN
    logic        byteswap       = 1'b0;
`endif
    logic        ioctl_wait;
    logic [27:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack         = 1'b1;
    logic        load_done;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rom_b [64];
    logic [43:0] got_q [$];
    bit          stall   = 1'b0;
    int          ack_dly = 0;
    bit          cap     = 1'b0;
    int          dly_cnt = 0;
    logic [43:0] cap_w   = '0;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(
        .FIFO_DEPTH (DEPTH),
        .PAD_BYTE   (PAD)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
`ifdef ROM_LOADER_BYTESWAP_EN
        .byteswap       (byteswap),
`endif
        .ioctl_wait     (ioctl_wait),
        .wraddr         (wraddr),
        .din            (din),
        .we_req         (we_req),
        .we_ack         (we_ack),
        .load_done      (load_done),
        .overrun        (overrun)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Controller: records each new request, checks it stays stable, acks after ack_dly cycles unless stalled.
    always @(negedge clk_sys) begin
        if (!reset && (we_req != we_ack)) begin
            if (!cap) begin
                cap     = 1'b1;
                cap_w   = {wraddr, din};
                dly_cnt = ack_dly;
                got_q.push_back({wraddr, din});
            end else begin
                check_val("req_hold", {wraddr, din}, cap_w);
            end
            if (!stall) begin
                if (dly_cnt == 0) begin
                    we_ack = ~we_ack;
                    cap    = 1'b0;
                end else begin
                    dly_cnt--;
                end
            end
        end else begin
            cap = 1'b0;
        end
    end

    task automatic run_download(input int n, input bit honor, input int max_gap);
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < n; i++) begin
            if (honor) begin
                int guard = 0;
                while (ioctl_wait && guard < 2000) begin
                    @(negedge clk_sys);
                    guard++;
                end
                if (guard >= 2000) check_val("wait_timeout", ioctl_wait, 0);
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 28'(i);
            ioctl_dout = rom_b[i];
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk_sys);
        end
        @(negedge clk_sys);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done(input logic [27:0] exp_addr, input string tag);
        int guard = 0;
        while (!load_done && guard < 5000) begin
            @(negedge clk_sys);
            guard++;
        end
        check_val({tag, "_done"}, load_done, 1);
        check_val({tag, "_final_wraddr"}, wraddr, exp_addr);
        @(negedge clk_sys);
        check_val({tag, "_done_pulse"}, load_done, 0);
    endtask

    // Model: accepted bytes 0..acc-1 form words in address order, missing odd bytes padded.
    task automatic check_writes(input int acc, input bit swp, input string tag);
        int nw = (acc + 1) / 2;
        check_val({tag, "_nwrites"}, got_q.size(), nw);
        for (int w = 0; w < nw && w < got_q.size(); w++) begin
            logic [7:0]  hi = rom_b[2*w];
            logic [7:0]  lo = (2*w + 1 < acc) ? rom_b[2*w+1] : PAD;
            logic [15:0] ew = swp ? {lo, hi} : {hi, lo};
            check_val({tag, "_wr_addr"}, got_q[w][43:16], 2*w);
            check_val({tag, "_wr_din"}, got_q[w][15:0], ew);
        end
    endtask

    function automatic logic [27:0] end_addr(input int acc);
        return 28'((acc + 1) & ~1);
    endfunction

    initial begin
        repeat (3) @(negedge clk_sys);
        check_val("rst_wraddr", wraddr, 0);
        check_val("rst_din", din, 0);
        check_val("rst_wait", ioctl_wait, 0);
        check_val("rst_done", load_done, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_we_req", we_req, 1);
        reset = 1'b0;
        @(negedge clk_sys);

        // Four bytes, ack after three cycles
        rom_b[0] = 8'h11; rom_b[1] = 8'h22; rom_b[2] = 8'h33; rom_b[3] = 8'h44;
        ack_dly = 3;
        got_q.delete();
        run_download(4, 1'b1, 0);
        wait_done(end_addr(4), "four");
        check_writes(4, 1'b0, "four");

        // Odd length
        rom_b[0] = 8'hAA; rom_b[1] = 8'hBB; rom_b[2] = 8'hCC;
        ack_dly = 1;
        got_q.delete();
        run_download(3, 1'b1, 1);
        wait_done(end_addr(3), "odd");
        check_writes(3, 1'b0, "odd");

        // Controller stall with a well-behaved host
        for (int i = 0; i < 16; i++) rom_b[i] = 8'($urandom);
        got_q.delete();
        stall = 1'b1;
        ack_dly = 0;
        fork
            run_download(16, 1'b1, 0);
            begin
                repeat (40) @(negedge clk_sys);
                check_val("stall_wait", ioctl_wait, 1);
                check_val("stall_reqs", got_q.size(), 1);
                stall = 1'b0;
            end
        join
        wait_done(end_addr(16), "stall");
        check_writes(16, 1'b0, "stall");
        check_val("stall_overrun", overrun, 0);

        // Host ignores ioctl_wait with acks frozen: only 2*DEPTH bytes fit
        for (int i = 0; i < 12; i++) rom_b[i] = 8'($urandom);
        got_q.delete();
        stall = 1'b1;
        run_download(12, 1'b0, 0);
        repeat (5) @(negedge clk_sys);
        check_val("ovr_flag", overrun, 1);
        check_val("ovr_reqs", got_q.size(), 1);
        stall = 1'b0;
        wait_done(end_addr(2 * DEPTH), "ovr");
        check_writes(2 * DEPTH, 1'b0, "ovr");
        check_val("ovr_sticky", overrun, 1);

        // Reset with a request pending
        got_q.delete();
        stall = 1'b1;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = 28'd0; ioctl_dout = 8'h5A;
        @(negedge clk_sys);
        ioctl_addr = 28'd1; ioctl_dout = 8'hA5;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_val("rstp_pending", we_req ^ we_ack, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check_val("rstp_req_eq_ack", we_req, we_ack);
        check_val("rstp_wraddr", wraddr, 0);
        check_val("rstp_din", din, 0);
        check_val("rstp_wait", ioctl_wait, 0);
        check_val("rstp_overrun", overrun, 0);
        repeat (5) @(negedge clk_sys);
        ioctl_download = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (we_req != we_ack || load_done) begin
                check_val("rstp_quiet_req", we_req, we_ack);
                check_val("rstp_quiet_done", load_done, 0);
            end
        end
        check_val("rstp_final_req", we_req, we_ack);
        check_val("rstp_nreqs", got_q.size(), 1);
        stall = 1'b0;

`ifdef ROM_LOADER_BYTESWAP_EN
        rom_b[0] = 8'h11; rom_b[1] = 8'h22;
        got_q.delete();
        byteswap = 1'b1;
        run_download(2, 1'b1, 0);
        wait_done(end_addr(2), "swap");
        check_writes(2, 1'b1, "swap");
        byteswap = 1'b0;
`endif

        // Randomized downloads
        for (int t = 0; t < 20; t++) begin
            int n = $urandom_range(20, 0);
            for (int i = 0; i < n; i++) rom_b[i] = 8'($urandom);
            ack_dly = $urandom_range(5, 0);
            got_q.delete();
            run_download(n, 1'b1, $urandom_range(3, 0));
            wait_done(end_addr(n), "rand");
            check_writes(n, 1'b0, "rand");
            check_val("rand_overrun", overrun, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
